// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: data-path width, instruction constants,
// fetch FSM state encoding and the {pc, instr} entry held by IF/ID and skid.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  // IDLE: no request; REQ: request live; DROP: request live but flushed
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor, wrapping modulo 2^XLEN
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched {pc, instr} that arrived while the
// IF/ID register was occupied and decode stalled.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push_i            capture pc_i/instr_i
//   pop_i             entry consumed by IF/ID
//   flush_i           discard the entry (redirect); wins over push/pop
//   pc_i, instr_i     entry to capture
//   full_o            entry present
//   pc_o, instr_o     held entry
module fetch_skid
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic         full_q;
  fetch_entry_t entry_q;

  // Occupancy and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q        <= 1'b0;
      entry_q.pc    <= '0;
      entry_q.instr <= NOP_INSTR;
    end else begin
      if (flush_i) begin
        full_q <= 1'b0;
      end else if (push_i) begin
        full_q <= 1'b1;
      end else if (pop_i) begin
        full_q <= 1'b0;
      end
      if (push_i && !flush_i) begin
        entry_q.pc    <= pc_i;
        entry_q.instr <= instr_i;
      end
    end
  end

  assign full_o  = full_q;
  assign pc_o    = entry_q.pc;
  assign instr_o = entry_q.instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack instruction-memory
// requests and feeds decode through a valid/ready IF/ID register backed by
// a one-entry skid. Redirects from the next-PC logic flush the stage.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   halt                          blocks new requests (in-flight one completes)
//   imem_req/imem_addr            fetch request and word address
//   imem_ack/imem_rdata           response, honoured only while imem_req=1
//   redirect/redirect_pc          taken-control-flow pulse and target
//   id_valid/id_ready             IF/ID handshake with decode
//   id_pc/id_instr/id_seq_addr    IF/ID payload, id_seq_addr = id_pc+4
//   fetch_err                     sticky misaligned-redirect flag
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_seq_addr,
  output logic            fetch_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;
  fetch_entry_t    id_q, id_d;
  logic [XLEN-1:0] seq_q, seq_d;

  logic            ack_c;
  logic            redir_ok_c;
  logic            redir_bad_c;
  logic            deliver_c;
  logic            launch_c;
  logic            new_req_c;
  logic            skid_push_c;
  logic            skid_pop_c;
  logic            skid_full_c;
  logic            skid_empty_nxt_c;
  logic [XLEN-1:0] skid_pc_c;
  logic [XLEN-1:0] skid_instr_c;

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (skid_push_c),
    .pop_i   (skid_pop_c),
    .flush_i (redirect),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .full_o  (skid_full_c),
    .pc_o    (skid_pc_c),
    .instr_o (skid_instr_c)
  );

  // Next-state, PC, request and IF/ID steering
  always_comb begin
    ack_c       = imem_ack & req_q;
    redir_ok_c  = redirect & (redirect_pc[1:0] == 2'b00);
    redir_bad_c = redirect & ~redir_ok_c;
    err_d       = err_q | redir_bad_c;
    // an ack in REQ is a real instruction unless a redirect kills it
    deliver_c   = ack_c & (state_q == REQ) & ~redirect;

    valid_d     = valid_q;
    id_d        = id_q;
    seq_d       = seq_q;
    skid_push_c = 1'b0;
    skid_pop_c  = 1'b0;

    // IF/ID: skid has priority over a fresh ack to keep program order
    if (redirect) begin
      valid_d = 1'b0;
    end else if (valid_q && id_ready) begin
      if (skid_full_c) begin
        id_d.pc    = skid_pc_c;
        id_d.instr = skid_instr_c;
        seq_d      = next_seq_pc(skid_pc_c);
        skid_pop_c = 1'b1;
      end else if (deliver_c) begin
        id_d.pc    = pc_q;
        id_d.instr = imem_rdata;
        seq_d      = next_seq_pc(pc_q);
      end else begin
        valid_d = 1'b0;
      end
    end else if (!valid_q) begin
      if (deliver_c) begin
        valid_d    = 1'b1;
        id_d.pc    = pc_q;
        id_d.instr = imem_rdata;
        seq_d      = next_seq_pc(pc_q);
      end
    end else begin
      skid_push_c = deliver_c;
    end

    skid_empty_nxt_c = redirect | ~(skid_push_c | (skid_full_c & ~skid_pop_c));
    launch_c         = ~halt & ~err_d & skid_empty_nxt_c;

    // Misaligned targets leave the PC untouched
    pc_d = pc_q;
    if (redirect) begin
      if (redir_ok_c) begin
        pc_d = redirect_pc;
      end
    end else if (deliver_c) begin
      pc_d = next_seq_pc(pc_q);
    end

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch_c) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_c) begin
          state_d = launch_c ? REQ : IDLE;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (ack_c) begin
          state_d = launch_c ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Address is reloaded only when a fresh request starts; held otherwise
    new_req_c = (state_d == REQ) & ((state_q != REQ) | ack_c);
    addr_d    = new_req_c ? pc_d : addr_q;
    req_d     = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      id_q.pc    <= '0;
      id_q.instr <= NOP_INSTR;
      seq_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      seq_q    <= seq_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_valid    = valid_q;
  assign id_pc       = id_q.pc;
  assign id_instr    = id_q.instr;
  assign id_seq_addr = seq_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with random/fixed ack latency returning
// a pc-derived instruction word, and a stream model of expected program order.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_seq_addr;
  logic        fetch_err;

  int tests;
  int fails;

  // memory model state
  int          mem_fixed;
  int          mem_wait;
  logic        mem_busy;
  logic        mem_spurious;
  logic [31:0] mem_addr;
  logic        mem_new;
  logic        addr_moved;
  logic        req_dropped;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_seq_addr (id_seq_addr),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder; called #1 after each rising edge
  task automatic mem_drive();
    mem_new     = 1'b0;
    addr_moved  = 1'b0;
    req_dropped = 1'b0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_new  = 1'b1;
        mem_addr = imem_addr;
        mem_wait = (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(0, 3));
      end else if (imem_addr !== mem_addr) begin
        addr_moved = 1'b1;
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = instr_of(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        mem_wait--;
      end
    end else begin
      if (mem_busy) req_dropped = 1'b1;
      mem_busy   = 1'b0;
      imem_ack   = mem_spurious && ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom();
    end
  endtask

  // Hold reset for two cycles and release just after a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    halt = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_wait = 0; mem_fixed = 0; mem_spurious = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    halt = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: req=%b valid=%b err=%b, required 0 0 0", imem_req, id_valid, fetch_err);
    end
    tests++;
    if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_seq_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: pc=%h instr=%h seq=%h, required all 0", id_pc, id_instr, id_seq_addr);
    end
    tests++;
    if (imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr: addr=%h, required 00000000", imem_addr);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    do_reset();
    id_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      mem_drive();
      @(negedge clk);
      if (k == 1) begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          fails++;
          $display("FAIL stream_first_req: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
        end
      end
      tests++;
      if (id_valid !== 1'(k >= 2)) begin
        fails++;
        $display("FAIL stream_valid c%0d: valid=%b, required %b", k, id_valid, 1'(k >= 2));
      end
      if (k >= 2) begin
        exp = 32'((k - 2) * 4);
        tests++;
        if (id_pc !== exp || id_seq_addr !== exp + 32'd4 || id_instr !== instr_of(exp)) begin
          fails++;
          $display("FAIL stream_data c%0d: pc=%h seq=%h instr=%h, required %h %h %h",
                   k, id_pc, id_seq_addr, id_instr, exp, exp + 32'd4, instr_of(exp));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int ndel;
    exp = 32'h0; ndel = 0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      id_ready = !(k >= 4 && k <= 6);
      mem_drive();
      @(negedge clk);
      if (id_valid && id_ready) begin
        tests++;
        if (id_pc !== exp || id_instr !== instr_of(exp) || id_seq_addr !== exp + 32'd4) begin
          fails++;
          $display("FAIL bp_order: pc=%h instr=%h seq=%h, required %h %h %h",
                   id_pc, id_instr, id_seq_addr, exp, instr_of(exp), exp + 32'd4);
        end
        exp += 32'd4; ndel++;
      end
      if (k == 6) begin
        tests++;
        if (imem_req !== 1'b0 || id_valid !== 1'b1) begin
          fails++;
          $display("FAIL bp_stall: req=%b valid=%b, required 0 1", imem_req, id_valid);
        end
      end
    end
    tests++;
    if (ndel < 10) begin
      fails++;
      $display("FAIL bp_count: delivered=%0d, required >=10", ndel);
    end
  endtask

  task automatic test_redirect_slow();
    logic [31:0] exp;
    int nreq, ndel;
    exp = 32'h0040_0100; nreq = 0; ndel = 0;
    do_reset();
    mem_fixed = 3; id_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      mem_drive();
      if (mem_new) begin
        nreq++;
        if (nreq == 2) begin
          tests++;
          if (imem_addr !== 32'h0040_0100) begin
            fails++;
            $display("FAIL redir_next_addr: addr=%h, required 00400100", imem_addr);
          end
        end
      end
      if (k == 1) begin
        redirect = 1'b1; redirect_pc = 32'h0040_0100;
      end
      tests++;
      if (addr_moved) begin
        fails++;
        $display("FAIL redir_addr_hold: addr=%h, required %h", imem_addr, mem_addr);
      end
      @(negedge clk);
      if (id_valid && id_ready) begin
        tests++;
        if (id_pc !== exp || id_instr !== instr_of(exp)) begin
          fails++;
          $display("FAIL redir_deliver: pc=%h instr=%h, required %h %h", id_pc, id_instr, exp, instr_of(exp));
        end
        exp += 32'd4; ndel++;
      end
    end
    tests++;
    if (ndel < 1 || nreq < 2) begin
      fails++;
      $display("FAIL redir_progress: delivered=%0d requests=%0d, required >=1 >=2", ndel, nreq);
    end
  endtask

  task automatic test_wrap_halt();
    logic [31:0] exp, inflight;
    logic top_seen, wrap_ok, inflight_seen, resumed;
    int halt_k;
    exp = 32'h0; inflight = '0; halt_k = 0;
    top_seen = 1'b0; wrap_ok = 1'b0; inflight_seen = 1'b0; resumed = 1'b0;
    do_reset();
    id_ready = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      mem_drive();
      if (k == 3) begin
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      end
      if (k == 8) mem_fixed = 2;
      if (k >= 9 && halt_k == 0 && mem_new) begin
        halt = 1'b1; halt_k = k; inflight = imem_addr;
      end
      if (halt_k != 0 && k == halt_k + 8) halt = 1'b0;
      if (halt_k != 0 && k > halt_k + 8 && mem_new) resumed = 1'b1;
      @(negedge clk);
      if (id_valid && id_ready) begin
        tests++;
        if (id_pc !== exp || id_instr !== instr_of(exp) || id_seq_addr !== exp + 32'd4) begin
          fails++;
          $display("FAIL wrap_order: pc=%h instr=%h seq=%h, required %h %h %h",
                   id_pc, id_instr, id_seq_addr, exp, instr_of(exp), exp + 32'd4);
        end
        if (top_seen && id_pc === 32'h0) wrap_ok = 1'b1;
        if (id_pc === 32'hFFFF_FFFC) top_seen = 1'b1;
        if (halt_k != 0 && id_pc === inflight) inflight_seen = 1'b1;
        exp += 32'd4;
      end
      if (redirect) exp = redirect_pc;
      if (halt_k != 0 && k >= halt_k + 4 && halt) begin
        tests++;
        if (imem_req !== 1'b0) begin
          fails++;
          $display("FAIL halt_no_req c%0d: req=%b addr=%h, required 0", k, imem_req, imem_addr);
        end
      end
    end
    tests++;
    if (!wrap_ok) begin
      fails++;
      $display("FAIL wrap_seen: got %b, required FFFFFFFC then 00000000 delivered", wrap_ok);
    end
    tests++;
    if (!inflight_seen || !resumed) begin
      fails++;
      $display("FAIL halt_flow: inflight_delivered=%b resumed=%b, required 1 1", inflight_seen, resumed);
    end
  endtask

  task automatic test_misaligned();
    logic fired, drained;
    fired = 1'b0; drained = 1'b0;
    do_reset();
    mem_fixed = 2; id_ready = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      mem_drive();
      if (!fired && k >= 8 && imem_req && !imem_ack) begin
        redirect = 1'b1; redirect_pc = 32'h0000_0102; fired = 1'b1;
      end
      @(negedge clk);
      if (fired && !redirect) begin
        tests++;
        if (fetch_err !== 1'b1 || id_valid !== 1'b0) begin
          fails++;
          $display("FAIL mis_flag c%0d: err=%b valid=%b, required 1 0", k, fetch_err, id_valid);
        end
        if (drained) begin
          tests++;
          if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL mis_no_req c%0d: req=%b, required 0", k, imem_req);
          end
        end
        if (imem_req && imem_ack) drained = 1'b1;
      end
    end
    tests++;
    if (!fired || !drained) begin
      fails++;
      $display("FAIL mis_drain: fired=%b drained=%b, required 1 1", fired, drained);
    end
    // asynchronous reset mid-cycle
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || fetch_err !== 1'b0 ||
        id_pc !== 32'h0 || id_instr !== 32'h0 || id_seq_addr !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: req=%b valid=%b err=%b pc=%h instr=%h seq=%h, required all 0",
               imem_req, id_valid, fetch_err, id_pc, id_instr, id_seq_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic prev_halt, prev_hold, flush_pend;
    int ndel;
    exp = 32'h0; ndel = 0;
    prev_halt = 1'b0; prev_hold = 1'b0; flush_pend = 1'b0;
    do_reset();
    mem_fixed = -1; mem_spurious = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk); #1;
      mem_drive();
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom() & 32'hFFFF_FFFC;
      id_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      @(negedge clk);
      tests++;
      if (addr_moved || req_dropped) begin
        fails++;
        $display("FAIL rnd_req_stable c%0d: moved=%b dropped=%b, required 0 0", k, addr_moved, req_dropped);
      end
      tests++;
      if (flush_pend && id_valid) begin
        fails++;
        $display("FAIL rnd_flush c%0d: valid=%b, required 0", k, id_valid);
      end
      tests++;
      if (prev_halt && !prev_hold && imem_req) begin
        fails++;
        $display("FAIL rnd_halt c%0d: req=%b, required 0", k, imem_req);
      end
      tests++;
      if (fetch_err !== 1'b0) begin
        fails++;
        $display("FAIL rnd_err c%0d: err=%b, required 0", k, fetch_err);
      end
      if (id_valid && id_ready) begin
        tests++;
        if (id_pc !== exp || id_instr !== instr_of(exp) || id_seq_addr !== exp + 32'd4) begin
          fails++;
          $display("FAIL rnd_stream c%0d: pc=%h instr=%h seq=%h, required %h %h %h",
                   k, id_pc, id_instr, id_seq_addr, exp, instr_of(exp), exp + 32'd4);
        end
        exp += 32'd4; ndel++;
      end
      flush_pend = redirect;
      if (redirect) exp = redirect_pc;
      prev_halt = halt;
      prev_hold = imem_req && !imem_ack;
    end
    tests++;
    if (ndel < 100) begin
      fails++;
      $display("FAIL rnd_progress: delivered=%0d, required >=100", ndel);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mem_fixed = 0; mem_wait = 0; mem_busy = 1'b0; mem_spurious = 1'b0;
    mem_addr = '0; mem_new = 1'b0; addr_moved = 1'b0; req_dropped = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_slow();
    test_wrap_halt();
    test_misaligned();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
